// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: an in-order register-file writeback queue.
// Each entry is a destination register index and its value. The head entry
// drains into the register-file write port whenever that port is free.
// Writes to register 0 are accepted from the producer but never stored.
// Optional pending-value lookup, enabled by defining
// REG_WRITEBACK_QUEUE_BYPASS_EN. With it, a read address that matches a
// queued entry returns the value from the youngest matching entry.
module reg_writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_addr,
  input  logic [31:0]              in_data,
  input  logic                     drain_en,
  input  logic                     flush,
  output logic                     regWrite,
  output logic [4:0]               waddr,
  output logic [31:0]              wdata,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [4:0]               raddr1,
  input  logic [4:0]               raddr2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [31:0]              hdata1,
  output logic [31:0]              hdata2
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]    r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(DEPTH));
  assign in_ready = !w_full;
  // A request to register 0 completes the handshake but is dropped here.
  assign w_push   = in_valid && in_ready && !flush && (in_addr != 5'd0);
  assign regWrite = drain_en && !w_empty;
  assign w_pop    = regWrite && !flush;
  assign count    = r_count;
  assign waddr    = w_empty ? '0 : r_addr[r_rptr];
  assign wdata    = w_empty ? '0 : r_data[r_rptr];

  // Entry storage: written at the tail on an accepted push.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else if (w_push) begin
      r_addr[r_wptr] <= in_addr;
      r_data[r_wptr] <= in_data;
    end
  end

  // Pointers and occupancy; flush overrides both push and pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
  logic [PW-1:0] w_idx;

  // Lookup walks entries oldest to youngest so the youngest match wins.
  always_comb begin
    hit1   = 1'b0;
    hit2   = 1'b0;
    hdata1 = '0;
    hdata2 = '0;
    w_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + PW'(i);
      if (CW'(i) < r_count) begin
        if ((raddr1 != 5'd0) && (r_addr[w_idx] == raddr1)) begin
          hit1   = 1'b1;
          hdata1 = r_data[w_idx];
        end
        if ((raddr2 != 5'd0) && (r_addr[w_idx] == raddr2)) begin
          hit2   = 1'b1;
          hdata2 = r_data[w_idx];
        end
      end
    end
  end
`else
  logic w_unused_raddr;

  assign w_unused_raddr = ^{raddr1, raddr2};
  assign hit1   = 1'b0;
  assign hit2   = 1'b0;
  assign hdata1 = '0;
  assign hdata2 = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed vector bench for reg_writeback_queue (DEPTH=4).
module tb_reg_writeback_queue;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic        flush;
  logic        regWrite;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [2:0]  count;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        hit1;
  logic        hit2;
  logic [31:0] hdata1;
  logic [31:0] hdata2;

  int total;
  int bad;

  reg_writeback_queue #(.DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .drain_en(drain_en), .flush(flush),
    .regWrite(regWrite), .waddr(waddr), .wdata(wdata), .count(count),
    .raddr1(raddr1), .raddr2(raddr2),
    .hit1(hit1), .hit2(hit2), .hdata1(hdata1), .hdata2(hdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic        de;
    logic        fl;
    logic        rdy;
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [2:0]  cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t tv [NV];

  function automatic vec_t mk(logic v, logic [4:0] a, logic [31:0] d, logic de, logic fl,
                              logic rdy, logic rw, logic [4:0] wa, logic [31:0] wd,
                              logic [2:0] cnt);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.de = de; r.fl = fl;
    r.rdy = rdy; r.rw = rw; r.wa = wa; r.wd = wd; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic de, input logic fl);
    @(negedge clk);
    in_valid = v; in_addr = a; in_data = d; drain_en = de; flush = fl;
    #1;
  endtask

  initial begin
    total = 0; bad = 0;
    rstn = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_en = 1'b0; flush = 1'b0; raddr1 = '0; raddr2 = '0;

    // Vectors: inputs applied before an edge, outputs checked before that edge.
    tv[0]  = mk(0, 5'd0,  32'h0,        0, 0, 1, 0, 5'd0, 32'h0,        3'd0);
    tv[1]  = mk(1, 5'd5,  32'hA5A5A5A5, 1, 0, 1, 0, 5'd0, 32'h0,        3'd0);
    tv[2]  = mk(0, 5'd0,  32'h0,        1, 0, 1, 1, 5'd5, 32'hA5A5A5A5, 3'd1);
    tv[3]  = mk(0, 5'd0,  32'h0,        0, 0, 1, 0, 5'd0, 32'h0,        3'd0);
    tv[4]  = mk(1, 5'd0,  32'h0000DEAD, 0, 0, 1, 0, 5'd0, 32'h0,        3'd0);
    tv[5]  = mk(0, 5'd0,  32'h0,        1, 0, 1, 0, 5'd0, 32'h0,        3'd0);
    tv[6]  = mk(1, 5'd1,  32'h11,       0, 0, 1, 0, 5'd0, 32'h0,        3'd0);
    tv[7]  = mk(1, 5'd2,  32'h22,       0, 0, 1, 0, 5'd1, 32'h11,       3'd1);
    tv[8]  = mk(1, 5'd3,  32'h33,       0, 0, 1, 0, 5'd1, 32'h11,       3'd2);
    tv[9]  = mk(1, 5'd4,  32'h44,       0, 0, 1, 0, 5'd1, 32'h11,       3'd3);
    tv[10] = mk(1, 5'd6,  32'h66,       0, 0, 0, 0, 5'd1, 32'h11,       3'd4);
    tv[11] = mk(1, 5'd6,  32'h66,       1, 0, 0, 1, 5'd1, 32'h11,       3'd4);
    tv[12] = mk(1, 5'd6,  32'h66,       1, 0, 1, 1, 5'd2, 32'h22,       3'd3);
    tv[13] = mk(0, 5'd0,  32'h0,        1, 0, 1, 1, 5'd3, 32'h33,       3'd3);
    tv[14] = mk(0, 5'd0,  32'h0,        1, 0, 1, 1, 5'd4, 32'h44,       3'd2);
    tv[15] = mk(0, 5'd0,  32'h0,        1, 0, 1, 1, 5'd6, 32'h66,       3'd1);
    tv[16] = mk(0, 5'd0,  32'h0,        0, 0, 1, 0, 5'd0, 32'h0,        3'd0);
    tv[17] = mk(1, 5'd7,  32'h77,       0, 0, 1, 0, 5'd0, 32'h0,        3'd0);
    tv[18] = mk(1, 5'd8,  32'h88,       0, 0, 1, 0, 5'd7, 32'h77,       3'd1);
    tv[19] = mk(1, 5'd9,  32'h99,       0, 0, 1, 0, 5'd7, 32'h77,       3'd2);
    tv[20] = mk(1, 5'd10, 32'hAA,       1, 1, 1, 1, 5'd7, 32'h77,       3'd3);
    tv[21] = mk(0, 5'd0,  32'h0,        1, 0, 1, 0, 5'd0, 32'h0,        3'd0);

    // Outputs while held in reset
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_hit1", 32'(hit1), 32'd0);
    chk("rst_hdata2", hdata2, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int k = 0; k < NV; k++) begin
      drive(tv[k].v, tv[k].a, tv[k].d, tv[k].de, tv[k].fl);
      chk($sformatf("v%0d_in_ready", k), 32'(in_ready), 32'(tv[k].rdy));
      chk($sformatf("v%0d_regWrite", k), 32'(regWrite), 32'(tv[k].rw));
      chk($sformatf("v%0d_waddr", k), 32'(waddr), 32'(tv[k].wa));
      chk($sformatf("v%0d_wdata", k), wdata, tv[k].wd);
      chk($sformatf("v%0d_count", k), 32'(count), 32'(tv[k].cnt));
      chk($sformatf("v%0d_hit1", k), 32'(hit1), 32'd0);
    end

    // Lookup: two pending writes to r3, youngest value must win
    drive(1, 5'd3, 32'h11, 0, 0);
    drive(1, 5'd3, 32'h22, 0, 0);
    drive(0, 5'd0, 32'h0, 0, 0);
    raddr1 = 5'd3; raddr2 = 5'd0;
    #1;
    chk("byp_count", 32'(count), 32'd2);
`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
    chk("byp_hit1", 32'(hit1), 32'd1);
    chk("byp_hdata1", hdata1, 32'h22);
`else
    chk("byp_hit1", 32'(hit1), 32'd0);
    chk("byp_hdata1", hdata1, 32'h0);
`endif
    chk("byp_hit2_r0", 32'(hit2), 32'd0);
    raddr2 = 5'd5;
    #1;
    chk("byp_hit2_miss", 32'(hit2), 32'd0);
    // Head {3,0x11} being popped this cycle still counts; youngest is 0x22
    drive(0, 5'd0, 32'h0, 1, 0);
    raddr2 = 5'd3;
    #1;
    chk("byp_pop_regWrite", 32'(regWrite), 32'd1);
    chk("byp_pop_wdata", wdata, 32'h11);
`ifdef REG_WRITEBACK_QUEUE_BYPASS_EN
    chk("byp_pop_hit2", 32'(hit2), 32'd1);
    chk("byp_pop_hdata2", hdata2, 32'h22);
`else
    chk("byp_pop_hit2", 32'(hit2), 32'd0);
    chk("byp_pop_hdata2", hdata2, 32'h0);
`endif
    drive(0, 5'd0, 32'h0, 0, 1);
    drive(0, 5'd0, 32'h0, 0, 0);
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    chk("byp_flush_count", 32'(count), 32'd0);
    chk("byp_flush_hit1", 32'(hit1), 32'd0);

    // Reset pulsed mid-drain with two entries queued
    drive(1, 5'd12, 32'hC, 0, 0);
    drive(1, 5'd13, 32'hD, 0, 0);
    drive(0, 5'd0, 32'h0, 1, 0);
    chk("mrst_pre_count", 32'(count), 32'd2);
    chk("mrst_pre_waddr", 32'(waddr), 32'd12);
    chk("mrst_pre_regWrite", 32'(regWrite), 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk("mrst_regWrite", 32'(regWrite), 32'd0);
    chk("mrst_waddr", 32'(waddr), 32'd0);
    chk("mrst_wdata", wdata, 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("mrst_rel_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_rel_count", 32'(count), 32'd0);
    drive(0, 5'd0, 32'h0, 1, 0);
    chk("mrst_rel_regWrite", 32'(regWrite), 32'd0);
    chk("mrst_rel_count2", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
